// File: rtl/gps_pkg.sv
// gps_pkg: shared GPS L1 C/A state type, code length and PRN G2 tap table
package gps_pkg;
  typedef enum logic [1:0] {IDLE, PRELOAD, RUN} state_t;
  localparam int CA_LEN = 1023;
  // {t1,t2} G2 phase-selector taps, one nibble each
  function automatic logic [7:0] prn_taps(input logic [5:0] sat);
    case (sat)
      6'd1:  return 8'h26;
      6'd2:  return 8'h37;
      6'd3:  return 8'h48;
      6'd4:  return 8'h59;
      6'd5:  return 8'h19;
      6'd6:  return 8'h2a;
      6'd7:  return 8'h18;
      6'd8:  return 8'h29;
      6'd9:  return 8'h3a;
      6'd10: return 8'h23;
      6'd11: return 8'h34;
      6'd12: return 8'h56;
      6'd13: return 8'h67;
      6'd14: return 8'h78;
      6'd15: return 8'h89;
      6'd16: return 8'h9a;
      6'd17: return 8'h14;
      6'd18: return 8'h25;
      6'd19: return 8'h36;
      6'd20: return 8'h47;
      6'd21: return 8'h58;
      6'd22: return 8'h69;
      6'd23: return 8'h13;
      6'd24: return 8'h46;
      6'd25: return 8'h57;
      6'd26: return 8'h68;
      6'd27: return 8'h79;
      6'd28: return 8'h8a;
      6'd29: return 8'h16;
      6'd30: return 8'h27;
      6'd31: return 8'h38;
      6'd32: return 8'h49;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/gps_ca_code_gen.sv
// gps_ca_code_gen: G1/G2 LFSR pair and chip counter producing C/A chips for one PRN
module gps_ca_code_gen
  import gps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic       advance,
  input  logic [5:0] sat,
  output logic       chip,
  output logic       epoch
);
  logic [10:1] g1, g2;
  logic [9:0] cnt;
  logic [3:0] t1, t2;
  assign {t1, t2} = prn_taps(sat);
  assign chip = g1[10] ^ g2[t1] ^ g2[t2];
  assign epoch = advance && cnt == 10'(CA_LEN - 1);
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      g1 <= '1;
      g2 <= '1;
      cnt <= '0;
    end else if (advance) begin
      g1 <= epoch ? '1 : {g1[9:1], g1[3] ^ g1[10]};
      g2 <= epoch ? '1 : {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
      cnt <= epoch ? '0 : cnt + 10'd1;
    end
  end
endmodule

// File: rtl/gps_ca_sig_gen.sv
// gps_ca_sig_gen: 1-bit I/Q GPS L1 C/A baseband generator with nav data and sample clock
module gps_ca_sig_gen
  import gps_pkg::*;
#(
  parameter int NCO_BITS       = 32,
  parameter int SAMPLE_DIV     = 4,
  parameter int EPOCHS_PER_BIT = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [5:0]          satelite,
  input  logic [9:0]          code_phase,
  input  logic [NCO_BITS-1:0] code_step,
  input  logic [NCO_BITS-1:0] carr_step,
  input  logic                nav_valid,
  input  logic                nav_bit,
  output logic                nav_ready,
  output logic                adc_clk,
  output logic                i_sample,
  output logic                q_sample,
  output logic                epoch,
  output logic                busy,
  output logic                cfg_err,
  output logic                nav_underrun
);
  localparam int DW = SAMPLE_DIV > 2 ? $clog2(SAMPLE_DIV) : 1;
  localparam int EW = EPOCHS_PER_BIT > 2 ? $clog2(EPOCHS_PER_BIT) : 1;
  state_t state, state_n;
  logic [5:0] sat_q;
  logic [9:0] pre;
  logic [DW-1:0] div;
  logic [EW-1:0] ep_cnt;
  logic [NCO_BITS-1:0] code_acc, carr_acc;
  logic [NCO_BITS:0] code_sum;
  logic cfg_ok, go, enter, tick, advance, take, chip, wrap, nav, nav_s, sin_s, cos_s;
  assign cfg_ok = satelite != 6'd0 && satelite <= 6'd32 && code_phase <= 10'd1022;
  assign go = state == IDLE && start && !stop && cfg_ok;
  assign enter = state == PRELOAD && pre == 10'd0 && !stop;
  // a sample tick loads the sample shown during the next divider count 0
  assign tick = enter || (state == RUN && div == DW'(SAMPLE_DIV - 1) && !stop);
  assign code_sum = {1'b0, code_acc} + {1'b0, code_step};
  assign advance = (state == PRELOAD && pre != 10'd0 && !stop) || (tick && code_sum[NCO_BITS]);
  assign take = enter || (state == RUN && wrap && ep_cnt == EW'(EPOCHS_PER_BIT - 1));
  assign nav_s = enter ? nav_valid & nav_bit : nav;
  assign sin_s = carr_acc[NCO_BITS-1];
  assign cos_s = carr_acc[NCO_BITS-1] ^ carr_acc[NCO_BITS-2];
  assign nav_ready = take && nav_valid;
  assign busy = state != IDLE;
  assign adc_clk = state == RUN && div < DW'(SAMPLE_DIV / 2);
  always_comb state_n = stop ? IDLE : go ? PRELOAD : enter ? RUN : state;
  gps_ca_code_gen u_code (
    .clk(clk), .rst(rst), .reload(go), .advance(advance), .sat(sat_q), .chip(chip), .epoch(wrap)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sat_q <= '0;
      pre <= '0;
      div <= '0;
      ep_cnt <= '0;
      code_acc <= '0;
      carr_acc <= '0;
      nav <= 1'b0;
      i_sample <= 1'b0;
      q_sample <= 1'b0;
      epoch <= 1'b0;
      cfg_err <= 1'b0;
      nav_underrun <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start && !stop) cfg_err <= !cfg_ok;
      if (go) begin
        sat_q <= satelite;
        pre <= code_phase;
        div <= '0;
        code_acc <= '0;
        carr_acc <= '0;
        nav_underrun <= 1'b0;
      end
      if (state == PRELOAD && pre != 10'd0) pre <= pre - 10'd1;
      if (state == RUN) div <= div == DW'(SAMPLE_DIV - 1) ? '0 : div + DW'(1);
      if (tick) begin
        i_sample <= chip ^ nav_s ^ cos_s;
        q_sample <= chip ^ nav_s ^ sin_s;
        code_acc <= code_sum[NCO_BITS-1:0];
        carr_acc <= carr_acc + carr_step;
      end
      if (take) begin
        nav <= nav_valid & nav_bit;
        ep_cnt <= '0;
        if (!nav_valid) nav_underrun <= 1'b1;
      end else if (state == RUN && wrap) ep_cnt <= ep_cnt + EW'(1);
      epoch <= state == RUN && wrap;
      if (stop) begin
        i_sample <= 1'b0;
        q_sample <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gps_ca_sig_gen.sv
// tb_gps_ca_sig_gen: directed checks of C/A chips, carrier signs, nav data, epochs and control
module tb_gps_ca_sig_gen;
  localparam int NB = 32;
  localparam int SD = 2;
  logic clk = 1'b0;
  logic rst, start, stop, nav_valid, nav_bit;
  logic nav_ready, adc_clk, i_sample, q_sample, epoch, busy, cfg_err, nav_underrun;
  logic [5:0] satelite;
  logic [9:0] code_phase;
  logic [NB-1:0] code_step, carr_step;
  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  logic [1022:0] ca1, ca2, per1;
  logic s_i, s_q, s_ep, s_ur;
  gps_ca_sig_gen #(.NCO_BITS(NB), .SAMPLE_DIV(SD), .EPOCHS_PER_BIT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .satelite(satelite),
    .code_phase(code_phase), .code_step(code_step), .carr_step(carr_step),
    .nav_valid(nav_valid), .nav_bit(nav_bit), .nav_ready(nav_ready), .adc_clk(adc_clk),
    .i_sample(i_sample), .q_sample(q_sample), .epoch(epoch), .busy(busy),
    .cfg_err(cfg_err), .nav_underrun(nav_underrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (nav_ready) ready_cnt++;
  function automatic logic [1022:0] ca_seq(input int t1, input int t2);
    logic [9:0] a = '1;
    logic [9:0] b = '1;
    logic [1022:0] s;
    for (int n = 0; n < 1023; n++) begin
      s[n] = a[9] ^ b[t1-1] ^ b[t2-1];
      a = {a[8:0], a[2] ^ a[9]};
      b = {b[8:0], b[1] ^ b[2] ^ b[5] ^ b[7] ^ b[8] ^ b[9]};
    end
    return s;
  endfunction
  function automatic logic [7:0] outs();
    return {busy, adc_clk, i_sample, q_sample, epoch, cfg_err, nav_underrun, nav_ready};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start(input logic [5:0] s, input logic [9:0] ph);
    satelite = s;
    code_phase = ph;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask
  task automatic get_sample();
    int n = 0;
    while (adc_clk && n < 2048) begin @(negedge clk); n++; end
    while (!adc_clk && n < 2048) begin @(negedge clk); n++; end
    if (n >= 2048) begin
      $display("FAIL sample_timeout: no adc_clk rise within %0d cycles", n);
      $fatal(1, "sample timeout");
    end
    s_i = i_sample;
    s_q = q_sample;
    s_ep = epoch;
    s_ur = nav_underrun;
  endtask
  initial begin
    logic [9:0] pat;
    int first_ep, bad, ep_bad, ur_bad, p2bad, r0, m, idx;
    logic sn, cs, ex;
    rst = 1'b1; start = 1'b0; stop = 1'b0; nav_valid = 1'b0; nav_bit = 1'b0;
    satelite = '0; code_phase = '0; code_step = '0; carr_step = '0;
    ca1 = ca_seq(2, 6);
    ca2 = ca_seq(3, 7);
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs()), 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(6'd0, 10'd0);
    check("sat0_busy_err", {busy, cfg_err}, 2'b01);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    pulse_start(6'd1, 10'd1023);
    check("phase1023_busy_err", {busy, cfg_err}, 2'b01);
    satelite = 6'd1; code_phase = 10'd0; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", {busy, cfg_err}, 2'b01);
    // PRN1, two samples per chip, no carrier, no nav
    code_step = 32'h8000_0000;
    pat = 10'o1440;
    pulse_start(6'd1, 10'd0);
    check("good_start_busy_err", {busy, cfg_err}, 2'b10);
    for (int k = 0; k < 20; k++) begin
      get_sample();
      check("prn1_iq", {s_i, s_q}, {2{pat[9 - k/2]}});
    end
    check("prn1_underrun", s_ur, 1);
    rst = 1'b1; @(negedge clk);
    check("rst_mid_run", 32'(outs()), 0);
    rst = 1'b0;
    pat = 10'o1620;
    pulse_start(6'd2, 10'd0);
    for (int k = 0; k < 20; k++) begin
      get_sample();
      check("prn2_iq", {s_i, s_q}, {2{pat[9 - k/2]}});
    end
    pulse_stop();
    // carrier quadrants, code frozen on PRN1 chip 0 (=1)
    code_step = '0;
    carr_step = 32'h4000_0000;
    pulse_start(6'd1, 10'd0);
    for (int k = 0; k < 8; k++) begin
      get_sample();
      m = k % 4;
      sn = m >= 2;
      cs = m == 1 || m == 2;
      check("carrier_iq", {s_i, s_q}, {~cs, ~sn});
    end
    pulse_stop();
    check("stop_outs", {busy, adc_clk, i_sample, q_sample, epoch, nav_ready}, 0);
    // PRN2 with code_phase 10: epoch on last chip after 1013 chips
    carr_step = '0;
    code_step = 32'h8000_0000;
    pulse_start(6'd2, 10'd10);
    first_ep = -1;
    bad = 0;
    for (int k = 0; k < 2100 && first_ep < 0; k++) begin
      get_sample();
      if (k == 0) check("prn2_ph10_first", s_q, ca2[10]);
      if (s_i !== s_q || s_q !== ca2[10 + k/2]) bad++;
      if (s_ep) first_ep = k;
    end
    check("prn2_ph10_data", bad, 0);
    check("prn2_ph10_epoch_idx", first_ep, 2025);
    pulse_stop();
    // nav bit 1 for 20 epochs, then underrun; ~1 chip per sample
    code_step = 32'hFFFF_FFFF;
    nav_valid = 1'b1;
    nav_bit = 1'b1;
    r0 = ready_cnt;
    pulse_start(6'd1, 10'd0);
    bad = 0; ep_bad = 0; ur_bad = 0; p2bad = 0;
    for (int k = 0; k <= 20470; k++) begin
      get_sample();
      if (k == 0) begin
        nav_valid = 1'b0;
        check("nav_first_inverted", {s_i, s_q}, {2{~ca1[0]}});
      end
      idx = k == 0 ? 0 : (k - 1) % 1023;
      ex = ca1[idx] ^ (k <= 20460);
      if (s_i !== ex || s_q !== ex) bad++;
      if (s_ep !== (k > 0 && k % 1023 == 0)) ep_bad++;
      if (s_ur !== (k >= 20460)) ur_bad++;
      if (k >= 1 && k <= 1023) per1[k-1] = s_q;
      if (k >= 1024 && k <= 2046 && s_q !== per1[k-1024]) p2bad++;
    end
    check("nav_data", bad, 0);
    check("nav_epochs", ep_bad, 0);
    check("nav_underrun_timing", ur_bad, 0);
    check("period2_identical", p2bad, 0);
    check("nav_ready_pulses", ready_cnt - r0, 1);
    pulse_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
